// File: rtl/arb_pkg.sv
// Shared constants and types for the four-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned PTR_W   = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // Last-served index out of reset, so requester a wins the first scan.
  localparam logic [PTR_W-1:0] PTR_RESET = 2'd3;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/student_mux4way16.sv
// Four-input word multiplexer feeding the arbiter's capture register.
module student_mux4way16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out_c
);

  always_comb begin
    out_c = a;
    case (sel)
      2'd0:    out_c = a;
      2'd1:    out_c = b;
      2'd2:    out_c = c;
      2'd3:    out_c = d;
      default: out_c = a;
    endcase
  end

endmodule

// File: rtl/student_arbiter4way16.sv
// Round-robin arbiter sharing one registered valid/ready output among four requesters.
// Define ARB_BURST_EN to hold ownership across grants until last[sel] or req[sel] drops.
module student_arbiter4way16
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] sel_next;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] data_next;
  logic             valid_next;
  logic             space;
  logic             grant;
  logic             release_on_grant;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand;

  student_mux4way16 #(.WIDTH(WIDTH)) u_mux (
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .sel   (sel),
    .out_c (mux_data)
  );

`ifdef ARB_BURST_EN
  assign release_on_grant = last[sel];
`else
  logic unused_last;
  assign unused_last      = ^last;
  assign release_on_grant = 1'b1;
`endif

  // First set request scanning ptr+1, ptr+2, ... wrapping modulo four.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    cand       = ptr;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = ptr + PTR_W'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign space = !out_valid || out_ready;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel;
    data_next  = out_data;
    valid_next = out_valid;
    gnt        = '0;
    grant      = 1'b0;

    if (out_valid && out_ready) begin
      valid_next = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          sel_next   = pick_idx;
          state_next = ST_OWN;
        end
      end
      ST_OWN: begin
        grant = req[sel] && space;
        if (grant) begin
          gnt        = NUM_REQ'(1) << sel;
          data_next  = mux_data;
          valid_next = 1'b1;
          if (release_on_grant) begin
            ptr_next   = sel;
            state_next = ST_IDLE;
          end
        end else if (!req[sel]) begin
          // Owner withdrew before being served: give up the slot, capture nothing.
          ptr_next   = sel;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= PTR_RESET;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      sel       <= sel_next;
      out_data  <= data_next;
      out_valid <= valid_next;
    end
  end

endmodule
